// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of the single-port memory: sequential wrapping addresses,
// 1 beat/cycle writes, registered 1-entry read stream with backpressure, done pulse.
module mem_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    done_q, done_d;
  logic                    rd_drain;
  logic                    rd_issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    rd_drain    = rd_valid_q & rd_ready;
    rd_issue    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          state_d     = cmd_write ? ST_WRITE : ST_READ;
        end
      end

      ST_WRITE: begin
        wr_ready  = 1'b1;
        mem_we    = wr_valid;
        mem_wdata = wr_data;
        if (wr_valid) begin
          cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      ST_READ: begin
        // Refill the output register whenever it is empty or emptying this cycle.
        rd_issue = ~rd_valid_q | rd_ready;
        if (rd_issue) begin
          rd_data_d   = mem_rdata;
          rd_valid_d  = 1'b1;
          cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == '0) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (rd_drain) begin
          rd_valid_d = 1'b0;
          state_d    = ST_IDLE;
          done_d     = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_addr = cur_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: behavioural memory + burst-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized bursts.
module tb_mem_burst_ctrl;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int LW = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic rd_valid;
  logic rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic busy, done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  logic [AW-1:0] we_addr[$];
  int we_cyc[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  int rcyc[$];

  mem_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Single-port memory: synchronous write, combinational read.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Burst-level reference model: what beat index each output must carry.
  bit m_active = 0, m_write = 0, m_done_next = 0, m_out_vld = 0, shadow_ok = 0;
  int m_base = 0, m_total = 0, m_issued = 0, m_taken = 0, m_out_idx = 0;
  bit prev_vld = 0, prev_rdy = 0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    bit was_idle, hs, issue;
    if (!shadow_ok) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] = mem[i];
      shadow_ok = 1;
    end
    if (rst) begin
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      m_active = 0; m_done_next = 0; m_out_vld = 0; prev_vld = 0;
    end else begin
      was_idle = !m_active;
      chk("done", 32'(done), 32'(m_done_next));
      chk("cmd_ready", 32'(cmd_ready), 32'(was_idle));
      chk("busy", 32'(busy), 32'(m_active));
      chk("wr_ready", 32'(wr_ready), 32'(m_active && m_write));
      chk("rd_valid", 32'(rd_valid), 32'(m_out_vld));
      if (m_out_vld) chk("rd_data", 32'(rd_data), 32'(shadow[(m_base + m_out_idx) % DEPTH]));
      if (prev_vld && !prev_rdy && rd_valid) chk("rd_hold", 32'(rd_data), 32'(prev_data));
      m_done_next = 0;
      if (m_active && m_write) begin
        chk("wr_mem_we", 32'(mem_we), 32'(wr_valid));
        chk("wr_addr", 32'(mem_addr), (m_base + m_issued) % DEPTH);
        if (wr_valid) begin
          chk("wr_wdata", 32'(mem_wdata), 32'(wr_data));
          shadow[(m_base + m_issued) % DEPTH] = wr_data;
          m_issued++;
          if (m_issued == m_total) begin m_active = 0; m_done_next = 1; end
        end
      end else begin
        chk("mem_we_zero", 32'(mem_we), 0);
        if (m_active) begin
          hs = m_out_vld && rd_ready;
          issue = (m_issued < m_total) && (!m_out_vld || rd_ready);
          if (m_issued < m_total) chk("rd_addr", 32'(mem_addr), (m_base + m_issued) % DEPTH);
          if (hs) m_taken++;
          if (issue) begin m_out_vld = 1; m_out_idx = m_issued; m_issued++; end
          else if (hs) m_out_vld = 0;
          if (hs && m_taken == m_total) begin m_active = 0; m_done_next = 1; end
        end
      end
      if (was_idle && cmd_valid) begin
        m_active = 1; m_write = cmd_write; m_base = int'(cmd_addr);
        m_total = int'(cmd_len) + 1; m_issued = 0; m_taken = 0;
      end
      prev_vld = rd_valid; prev_rdy = rd_ready; prev_data = rd_data;
    end
  end

  always @(negedge clk) begin
    if (!rst && done) n_done++;
    if (!rst && mem_we) begin we_addr.push_back(mem_addr); we_cyc.push_back(cyc); end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit w, input int a, input int len);
    int g = 0;
    bit acc = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = AW'(a); cmd_len = LW'(len);
    while (!acc && g < 1000) begin
      @(negedge clk);
      acc = cmd_ready && !rst;
      tick();
      g++;
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 32'(acc), 1);
  endtask

  task automatic do_write(input int a, input int len, input int stall_at, input int stall_n,
                          input int stall_pct);
    int i = 0, g = 0, left = stall_n;
    bit hs;
    send_cmd(1'b1, a, len);
    while (i <= len && g < 20000) begin
      if (i == stall_at && left > 0) begin
        wr_valid = 1'b0;
        left--;
        @(negedge clk);
        chk("stall_mem_we", 32'(mem_we), 0);
        chk("stall_addr", 32'(mem_addr), (a + stall_at) % DEPTH);
        tick();
      end else begin
        wr_valid = ($urandom_range(99) >= stall_pct);
        wr_data = wq[i];
        @(negedge clk);
        hs = wr_valid && wr_ready;
        tick();
        if (hs) i++;
      end
      g++;
    end
    wr_valid = 1'b0;
    chk("wr_beats", i, len + 1);
  endtask

  task automatic do_read(input int a, input int len, input int mode, input int abort_after);
    int k = 0, ph = 0, g = 0;
    rq.delete(); rcyc.delete();
    send_cmd(1'b0, a, len);
    while (k <= len && g < 20000 && !(abort_after >= 0 && k == abort_after)) begin
      case (mode)
        0: rd_ready = 1'b1;
        1: rd_ready = (ph % 3 == 0);
        default: rd_ready = 1'($urandom_range(1));
      endcase
      ph++;
      @(negedge clk);
      if (rd_valid && rd_ready) begin rq.push_back(rd_data); rcyc.push_back(cyc); k++; end
      tick();
      g++;
    end
    rd_ready = 1'b0;
    if (abort_after < 0) chk("rd_beats", k, len + 1);
  endtask

  initial begin
    int s, d0, a, len;
    logic [DW-1:0] exp_wb [4];
    logic [DW-1:0] exp_st [4];
    exp_wb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    exp_st = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 1);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_mem_we", 32'(mem_we), 0);
    chk("reset_done", 32'(done), 0);
    tick();

    // Write burst then read back.
    wq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    s = we_addr.size(); d0 = n_done;
    do_write('h010, 3, -1, 0, 0);
    tick(); tick();
    chk("wb_we_count", we_addr.size() - s, 4);
    if (we_addr.size() - s >= 4)
      for (int j = 0; j < 4; j++) begin
        chk("wb_we_addr", 32'(we_addr[s + j]), 'h010 + j);
        chk("wb_we_consecutive", we_cyc[s + j] - we_cyc[s], j);
      end
    chk("wb_done_once", n_done - d0, 1);

    d0 = n_done;
    do_read('h010, 3, 0, -1);
    tick(); tick();
    if (rq.size() == 4)
      for (int j = 0; j < 4; j++) begin
        chk("rb_data", 32'(rq[j]), 32'(exp_wb[j]));
        chk("rb_consecutive", rcyc[j] - rcyc[0], j);
      end
    chk("rb_done_once", n_done - d0, 1);

    // Write with a 2-cycle stall before the second beat.
    wq = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    do_write('h010, 3, 1, 2, 0);
    tick();
    for (int j = 0; j < 4; j++) chk("stall_mem_content", 32'(mem['h010 + j]), 32'(exp_st[j]));

    // Read with rd_ready 1,0,0,1,...
    d0 = n_done;
    do_read('h010, 3, 1, -1);
    tick(); tick();
    if (rq.size() == 4)
      for (int j = 0; j < 4; j++) chk("bp_data", 32'(rq[j]), 32'(exp_st[j]));
    chk("bp_done_once", n_done - d0, 1);

    // Address wrap.
    wq = '{8'h11, 8'h22, 8'h33};
    do_write('h3FE, 2, -1, 0, 0);
    tick();
    chk("wrap_3fe", 32'(mem['h3FE]), 'h11);
    chk("wrap_3ff", 32'(mem['h3FF]), 'h22);
    chk("wrap_000", 32'(mem['h000]), 'h33);

    // Reset in the middle of an 8-beat read.
    do_read('h100, 7, 0, 2);
    d0 = n_done;
    rst = 1'b1;
    #1;
    chk("midrst_rd_valid", 32'(rd_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("midrst_no_done", n_done - d0, 0);
    do_read('h010, 1, 0, -1);
    if (rq.size() == 2) begin
      chk("post_rst_rd0", 32'(rq[0]), 'hE1);
      chk("post_rst_rd1", 32'(rq[1]), 'hE2);
    end
    tick();

    // Randomized bursts, including back-to-back commands and full-length bursts.
    for (int it = 0; it < 40; it++) begin
      a = ($urandom_range(3) == 0) ? DEPTH - 1 - int'($urandom_range(5)) : int'($urandom_range(DEPTH - 1));
      len = ($urandom_range(11) == 0) ? 255 : int'($urandom_range(12));
      if ($urandom_range(1) == 1) begin
        wq.delete();
        for (int j = 0; j <= len; j++) wq.push_back(8'($urandom));
        do_write(a, len, -1, 0, int'($urandom_range(50)));
      end else begin
        do_read(a, len, 2, -1);
      end
      repeat ($urandom_range(2)) tick();
    end
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "timeout");
  end

endmodule
